// File: rtl/keyboard_event_fifo.sv
// Buffers PS/2 key events and serves READKEY pop/peek into the integer regfile.
// Define KEYBOARD_DROP_BREAK_EN to buffer make codes only.
module keyboard_event_fifo #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [5:0] READKEY    = 6'h2A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        key_valid,
  input  logic [7:0]  key_status,
  input  logic [7:0]  keycode,
  output logic        enable,
  output logic        float,
  output logic [4:0]  addr,
  output logic [31:0] data,
  output logic        key_pending
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LP_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] LP_PTR1 = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [15:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf;
  logic                  r_en;
  logic [4:0]            r_addr;
  logic [31:0]           r_data;
  logic                  r_pend;

  logic                  w_rd;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_evt;
  logic                  w_push;
  logic                  w_ovf_set;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic [15:0]           w_head;
  logic                  w_unused;

  assign w_unused = ^{inst[25:21], inst[15:1]};

  assign w_rd    = (inst[31:26] == READKEY);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_FULL);
  assign w_pop   = w_rd && !w_empty && !inst[0];
  assign w_head  = r_mem[r_rptr];

`ifdef KEYBOARD_DROP_BREAK_EN
  assign w_evt = key_valid && !key_status[0];
`else
  assign w_evt = key_valid;
`endif

  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign w_push    = w_evt && (!w_full || w_pop);
  assign w_ovf_set = w_evt && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) w_count_nxt = r_count + LP_ONE;
    else if (w_pop && !w_push) w_count_nxt = r_count - LP_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wptr] <= {key_status, keycode};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_pend  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + LP_PTR1;
      if (w_pop)  r_rptr <= r_rptr + LP_PTR1;
      r_count <= w_count_nxt;
      r_pend  <= (w_count_nxt != '0);
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (w_rd) r_ovf <= 1'b0;
      r_en <= w_rd;
      if (w_rd) begin
        r_addr <= inst[20:16];
        if (w_empty) r_data <= {1'b1, r_ovf, 30'b0};
        else         r_data <= {1'b0, r_ovf, 14'b0, w_head};
      end
    end
  end

  assign enable      = r_en;
  assign float       = 1'b0;
  assign addr        = r_addr;
  assign data        = r_data;
  assign key_pending = r_pend;

endmodule

// File: tb/tb_keyboard_event_fifo.sv
// Scoreboard bench: READKEY issues queue expected writes, a monitor checks them.
`timescale 1ns/1ps
module tb_keyboard_event_fifo;

  localparam logic [5:0] OP_RK = 6'h2A;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        key_valid;
  logic [7:0]  key_status;
  logic [7:0]  keycode;
  logic        enable;
  logic        float;
  logic [4:0]  addr;
  logic [31:0] data;
  logic        key_pending;

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] exp_q [$];

  always #5 clk = ~clk;

  keyboard_event_fifo #(.DEPTH_LOG2(2), .READKEY(OP_RK)) dut (
    .clk(clk), .rst(rst), .inst(inst), .key_valid(key_valid),
    .key_status(key_status), .keycode(keycode), .enable(enable),
    .float(float), .addr(addr), .data(data), .key_pending(key_pending)
  );

  function automatic logic [31:0] rk(input logic [4:0] d, input logic pk);
    return {OP_RK, 5'd0, d, 15'd0, pk};
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    inst = 32'h0;
  endtask

  task automatic push(input logic [7:0] st, input logic [7:0] kc);
    key_valid = 1'b1; key_status = st; keycode = kc;
    step();
  endtask

  task automatic read(input logic [4:0] d, input logic pk,
                      input logic [31:0] exp);
    inst = rk(d, pk);
    exp_q.push_back({d, exp});
    step();
  endtask

  // Monitor: every enable pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_enable: addr %0d data %h", addr, data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, addr}, {27'd0, e[36:32]});
        check("wr_data", data, e[31:0]);
      end
    end
    if (float !== 1'b0) begin
      n_tests++; n_fail++;
      $display("FAIL float: got %b expected 0", float);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; inst = 32'h0; key_valid = 1'b0;
    key_status = 8'h0; keycode = 8'h0;
    step(); step();
    check("rst_enable", {31'd0, enable}, 32'd0);
    check("rst_addr", {27'd0, addr}, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_pending", {31'd0, key_pending}, 32'd0);
    rst = 1'b0;

    // ordered pops
    push(8'h00, 8'h1C); push(8'h00, 8'h32); push(8'h00, 8'h21);
    check("pend_after_push", {31'd0, key_pending}, 32'd1);
    read(5'd5, 1'b0, 32'h0000_001C);
    read(5'd5, 1'b0, 32'h0000_0032);
    check("pend_two_left", {31'd0, key_pending}, 32'd1);
    read(5'd5, 1'b0, 32'h0000_0021);
    check("pend_drained", {31'd0, key_pending}, 32'd0);

    // empty pop and peek
    read(5'd3, 1'b0, 32'h8000_0000);
    read(5'd3, 1'b1, 32'h8000_0000);

    // overflow on depth 4
    push(8'h00, 8'hA1); push(8'h00, 8'hA2); push(8'h00, 8'hA3);
    push(8'h00, 8'hA4); push(8'h00, 8'hA5);
    read(5'd7, 1'b0, 32'h4000_00A1);
    read(5'd7, 1'b0, 32'h0000_00A2);
    read(5'd7, 1'b0, 32'h0000_00A3);
    read(5'd7, 1'b0, 32'h0000_00A4);
    read(5'd7, 1'b0, 32'h8000_0000);

    // full with simultaneous push and pop
    push(8'h00, 8'hB1); push(8'h00, 8'hB2);
    push(8'h00, 8'hB3); push(8'h00, 8'hB4);
    key_valid = 1'b1; key_status = 8'h00; keycode = 8'hB5;
    read(5'd8, 1'b0, 32'h0000_00B1);
    read(5'd8, 1'b0, 32'h0000_00B2);
    read(5'd8, 1'b0, 32'h0000_00B3);
    read(5'd8, 1'b0, 32'h0000_00B4);
    read(5'd8, 1'b0, 32'h0000_00B5);
    read(5'd8, 1'b0, 32'h8000_0000);

    // peek, peek, pop, pop; status bits forwarded
    push(8'h80, 8'hC1); push(8'h00, 8'hC2);
    read(5'd9, 1'b1, 32'h0000_80C1);
    read(5'd9, 1'b1, 32'h0000_80C1);
    read(5'd9, 1'b0, 32'h0000_80C1);
    read(5'd9, 1'b0, 32'h0000_00C2);

    // push into empty while reading: no bypass
    key_valid = 1'b1; key_status = 8'h00; keycode = 8'hD1;
    read(5'd10, 1'b0, 32'h8000_0000);
    read(5'd11, 1'b0, 32'h0000_00D1);

    // non-READKEY holds addr/data
    inst = 32'h0400_001F;
    step();
    check("hold_addr", {27'd0, addr}, 32'd11);
    check("hold_data", data, 32'h0000_00D1);
    check("hold_enable", {31'd0, enable}, 32'd0);

    // reset with entries queued and READKEY pending
    push(8'h00, 8'hE1); push(8'h00, 8'hE2); push(8'h00, 8'hE3);
    rst = 1'b1; inst = rk(5'd4, 1'b0);
    key_valid = 1'b1; keycode = 8'hE4;
    step();
    check("rst_rd_enable", {31'd0, enable}, 32'd0);
    check("rst_rd_data", data, 32'd0);
    check("rst_rd_pending", {31'd0, key_pending}, 32'd0);
    rst = 1'b0;
    read(5'd4, 1'b0, 32'h8000_0000);

    // break code handling
    push(8'h01, 8'hF0);
`ifdef KEYBOARD_DROP_BREAK_EN
    check("break_pending", {31'd0, key_pending}, 32'd0);
    read(5'd12, 1'b0, 32'h8000_0000);
`else
    check("break_pending", {31'd0, key_pending}, 32'd1);
    read(5'd12, 1'b0, 32'h0000_01F0);
`endif

    step(); step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keyboard_event_fifo.md
# keyboard_event_fifo

Buffered successor to the single-shot keyboard reader: captures PS/2 key events into a parametrised FIFO and services `READKEY` instructions by popping or peeking the oldest event into the integer register file. Sits between the PS/2 decoder and the register-file write arbiter, beside the other I/O readers. No event is lost while the CPU is busy, and an empty FIFO and overflows are both reported to software.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth is 2**DEPTH_LOG2 entries (range 1–8).

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `inst`  in  32  instruction word; op = `inst[31:26]`, destination = `inst[20:16]`, peek flag = `inst[0]`.
- `key_valid`  in  1  one-cycle strobe; a new event is present on `key_status`/`keycode`.
- `key_status`  in  8  bit0 = break code, bits 7:1 forwarded untouched.
- `keycode`  in  8  scan code.
- `enable`  out  1  register write request, one cycle.
- `float`  out  1  constant 0 (integer register file).
- `addr`  out  5  destination register.
- `data`  out  32  `{empty, overflow, 14'b0, status[7:0], code[7:0]}`.
- `key_pending`  out  1  FIFO non-empty (registered).

## Operation
- Storage: 2**DEPTH_LOG2 × 16-bit entries `{key_status, keycode}`. Read and write pointers are DEPTH_LOG2 bits and wrap modulo depth. `count` is DEPTH_LOG2+1 bits.
- Push: when `key_valid` is high and count < depth, write the entry and advance the write pointer. When `key_valid` is high and the FIFO is full, drop the event and set sticky `overflow`.
- Instruction: when op == `READKEY`, the block always responds (unlike the previous generation). `enable` = 1, `addr` = `inst[20:16]`.
  - Non-empty: data[15:0] = head entry, data[31] = 0. If `inst[0]` = 0 (pop), advance the read pointer. If `inst[0]` = 1 (peek), the pointer is unchanged.
  - Empty: data[15:0] = 0, data[31] = 1, no pointer change.
  - data[30] = the `overflow` value before this cycle. Any READKEY (pop, peek or empty) clears `overflow`, unless the same cycle sets it again. A set wins over a clear.
- Simultaneous push and pop:
  - Non-empty and not full: both happen, count is unchanged.
  - Full: the pop frees a slot, so the push is accepted and overflow is not set.
  - Empty: the instruction reports empty and the push is stored. There is no bypass.
- Non-READKEY op: `enable` = 0, and `addr`/`data` hold their previous values.
- Reset: pointers = 0, count = 0, overflow = 0, `enable` = 0, `addr` = 0, `data` = 0, `key_pending` = 0. A `key_valid` or READKEY in the same cycle as `rst` is ignored. The storage array is not cleared.

## Timing
- Instruction to `enable`/`data` is 1 cycle (registered outputs sampled on the posedge after `inst` is presented).
- Push latency: an event strobed in cycle N is poppable by a READKEY presented in cycle N+1, and `key_pending` rises in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- `inst` is assumed stable for one cycle per instruction. Issuing the same READKEY on consecutive cycles pops on each cycle.

## Configuration
- `KEYBOARD_DROP_BREAK_EN` defined: events with `key_status[0]` = 1 (break) are never pushed and never set overflow. Only make events are buffered.
- Undefined: every strobed event is buffered regardless of `key_status`.

## Test plan
- Push keycodes 0x1C, 0x32, 0x21, then three READKEY pops to r5 -> `enable` pulses with addr = 5 and data[7:0] = 0x1C, 0x32, 0x21 in order; `key_pending` drops after the third pop.
- READKEY on an empty FIFO -> `enable` = 1, data = 0x8000_0000; a following peek also returns 0x8000_0000.
- DEPTH_LOG2 = 2: push 5 events -> 5th dropped. The first pop returns data[30] = 1 and the first event. The second pop returns data[30] = 0.
- Full FIFO with push and pop in the same cycle -> pop returns the head, the new event is stored, overflow stays 0, and count stays at 4.
- Peek (`inst[0]` = 1) twice, then pop -> all three return the same entry; the next pop returns the second entry.
- Assert `rst` with 3 entries queued and a READKEY pending -> that cycle gives `enable` = 0. A READKEY after reset returns the empty marker. With `KEYBOARD_DROP_BREAK_EN`, a break event (status 0x01) leaves `key_pending` = 0.
